// File: rtl/ika3012_so_decoder_pkg.sv
// Frame constants and word layout shared by the YM3012-style serial sound decoder.
package ika3012_so_decoder_pkg;

  localparam int unsigned FRAME_BITS           = 13;
  localparam int unsigned MANT_BITS            = 9;
  localparam int unsigned SIGN_POS             = 9;
  localparam int unsigned EXP_LSB              = 10;
  localparam int unsigned SLOTS_PER_HALF_FRAME = 16;

  typedef logic [FRAME_BITS-1:0] so_word_t;

  // Field order matches the shift register contents at frame end: {e[2:0], s, m[8:0]}
  typedef struct packed {
    logic [FRAME_BITS-EXP_LSB-1:0] expo;
    logic                          sign;
    logic [MANT_BITS-1:0]          mant;
  } so_fields_t;

  function automatic so_fields_t unpack_word(input so_word_t w);
    return so_fields_t'(w);
  endfunction

endpackage

// File: rtl/ika3012_fp_expand.sv
// Combinational floating-point to 16-bit two's-complement expansion of one DAC word.
module ika3012_fp_expand
  import ika3012_so_decoder_pkg::*;
(
  input  logic [FRAME_BITS-1:0] word,
  output logic [15:0]           sample,
  output logic                  exp_zero
);

  so_fields_t  f;
  logic [20:0] placed;
  logic [14:0] body;

  // Mantissa sits with its LSB at bit e-1; placing it for e=7 and shifting right by
  // (7-e) pulls the ~s fill down above it, and the top fill bits fall off the cast.
  always_comb begin
    f        = unpack_word(word);
    placed   = {{6{~f.sign}}, f.mant, 6'b0};
    body     = 15'(placed >> (3'd7 - f.expo));
    exp_zero = (f.expo == 3'd0);
    sample   = exp_zero ? '0 : {~f.sign, body};
  end

endmodule

// File: rtl/ika3012_so_decoder.sv
// Deserialises the SO/SH1/SH2 DAC stream into registered right/left 16-bit samples.
module ika3012_so_decoder
  import ika3012_so_decoder_pkg::*;
(
  input  logic        i_EMUCLK,
  input  logic        i_MRST_n,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_R,
  output logic [15:0] o_L,
  output logic        o_R_VALID,
  output logic        o_L_VALID,
  output logic        o_FRAME_ERR
);

  logic        en;
  so_word_t    sr, word_r, word_l;
  logic        sh1_z, sh2_z;
  logic        cap_r, cap_l;
  logic        pend_r, pend_l;
  logic [15:0] dec_r, dec_l;
  logic        zero_r, zero_l;

  always_comb begin
    en    = ~i_phi1_NCEN_n;
    cap_r = sh1_z & ~i_SH1;
    cap_l = sh2_z & ~i_SH2;
  end

  // Capture takes the pre-shift register, so the word framed by the strobe is kept intact.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      sr     <= '0;
      sh1_z  <= 1'b0;
      sh2_z  <= 1'b0;
      word_r <= '0;
      word_l <= '0;
      pend_r <= 1'b0;
      pend_l <= 1'b0;
    end else if (en) begin
      sr     <= {i_SO, sr[FRAME_BITS-1:1]};
      sh1_z  <= i_SH1;
      sh2_z  <= i_SH2;
      pend_r <= cap_r;
      pend_l <= cap_l;
      if (cap_r) word_r <= sr;
      if (cap_l) word_l <= sr;
    end
  end

  ika3012_fp_expand u_expand_r (
    .word     (word_r),
    .sample   (dec_r),
    .exp_zero (zero_r)
  );

  ika3012_fp_expand u_expand_l (
    .word     (word_l),
    .sample   (dec_l),
    .exp_zero (zero_l)
  );

  // Pulses clear on the very next EMUCLK even when that edge is not enabled.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      o_R         <= '0;
      o_L         <= '0;
      o_R_VALID   <= 1'b0;
      o_L_VALID   <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      o_R_VALID   <= 1'b0;
      o_L_VALID   <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      if (en) begin
        if (pend_r) begin
          o_R       <= dec_r;
          o_R_VALID <= 1'b1;
        end
        if (pend_l) begin
          o_L       <= dec_l;
          o_L_VALID <= 1'b1;
        end
        o_FRAME_ERR <= (pend_r & zero_r) | (pend_l & zero_l);
      end
    end
  end

endmodule
